// File: rtl/leaf_user2bft_packetizer_if.sv
// -----------------------------------------------------------------------------
// leaf_user2bft_packetizer_if
// Bundles the user-side word handshake and the BFT-side packet/flow-control
// signals of one leaf user output port.
//
// Signals
//   din_user    user word from the HLS kernel
//   vld_user    user word valid (ap_vld)
//   ack_user    user word accepted this cycle (ap_ack)
//   credit_vld  one-cycle freespace update from the receiver
//   resend      network rejected the packet currently on dout_bft
//   dout_bft    packet toward the switch network, MSB = valid
//
// Modports
//   master  kernel / network side (drives words, credits and resend)
//   slave   packetizer side (returns ack and drives packets)
// -----------------------------------------------------------------------------
interface leaf_user2bft_packetizer_if #(
    parameter int PAYLOAD_BITS = 32,
    parameter int PACKET_BITS  = 49
);
    logic [PAYLOAD_BITS-1:0] din_user;
    logic                    vld_user;
    logic                    ack_user;
    logic                    credit_vld;
    logic                    resend;
    logic [PACKET_BITS-1:0]  dout_bft;

    modport master (
        output din_user,
        output vld_user,
        output credit_vld,
        output resend,
        input  ack_user,
        input  dout_bft
    );

    modport slave (
        input  din_user,
        input  vld_user,
        input  credit_vld,
        input  resend,
        output ack_user,
        output dout_bft
    );
endinterface

// File: rtl/leaf_user2bft_packetizer.sv
// -----------------------------------------------------------------------------
// leaf_user2bft_packetizer
// Transmit-side packetizer for one user output port of a BFT leaf. 32-bit user
// words are buffered in a small FIFO and launched as 49-bit packets
// {valid, leaf, port, addr, payload}. A launch consumes one receiver credit;
// credits come back in blocks of FREESPACE_UPDATE_SIZE on credit_vld. A packet
// rejected by the network (resend) is held unchanged on the bus.
//
// Ports
//   clk_bft         single clock, rising edge
//   reset_n         synchronous active-low reset
//   cfg_dst_leaf    destination leaf, sampled at each launch
//   cfg_dst_port    destination port, sampled at each launch
//   user_bft        interface (slave): din_user/vld_user/ack_user,
//                   credit_vld, resend, dout_bft
//   stat_pkts_sent  consumed packet count      (only with PKT_STATS_EN)
//   stat_resends    SEND & resend cycle count  (only with PKT_STATS_EN)
//
// Build option
//   PKT_STATS_EN    when defined, adds the two wrapping statistics counters.
// -----------------------------------------------------------------------------
module leaf_user2bft_packetizer #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int FIFO_DEPTH_BITS       = 3,
    parameter int CREDIT_INIT           = 128,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                     clk_bft,
    input  logic                     reset_n,
    input  logic [NUM_LEAF_BITS-1:0] cfg_dst_leaf,
    input  logic [NUM_PORT_BITS-1:0] cfg_dst_port,
`ifdef PKT_STATS_EN
    output logic [31:0]              stat_pkts_sent,
    output logic [31:0]              stat_resends,
`endif
    leaf_user2bft_packetizer_if.slave user_bft
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int FIFO_DEPTH = 1 << FIFO_DEPTH_BITS;
    // Wide enough to hold CREDIT_INIT + one update before saturation.
    localparam int CRED_W     = $clog2(CREDIT_INIT + FREESPACE_UPDATE_SIZE + 1);

    localparam logic [FIFO_DEPTH_BITS:0]   C_CNT_FULL  = (FIFO_DEPTH_BITS+1)'(FIFO_DEPTH);
    localparam logic [FIFO_DEPTH_BITS:0]   C_CNT_ONE   = (FIFO_DEPTH_BITS+1)'(1);
    localparam logic [FIFO_DEPTH_BITS-1:0] C_PTR_ONE   = FIFO_DEPTH_BITS'(1);
    localparam logic [CRED_W-1:0]          C_CRED_INIT = CRED_W'(CREDIT_INIT);
    localparam logic [CRED_W-1:0]          C_CRED_UPD  = CRED_W'(FREESPACE_UPDATE_SIZE);
    localparam logic [CRED_W-1:0]          C_CRED_ONE  = CRED_W'(1);
    localparam logic [NUM_ADDR_BITS-1:0]   C_ADDR_ONE  = NUM_ADDR_BITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [PAYLOAD_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] r_wr_ptr;
    logic [FIFO_DEPTH_BITS-1:0] r_rd_ptr;
    logic [FIFO_DEPTH_BITS:0]  r_count;
    logic [FIFO_DEPTH_BITS:0]  w_count_nxt;

    logic [CRED_W-1:0]         r_credits;
    logic [CRED_W-1:0]         w_cred_dec;
    logic [CRED_W-1:0]         w_cred_add;
    logic [CRED_W-1:0]         w_credits_nxt;

    logic [NUM_ADDR_BITS-1:0]  r_addr;
    logic [NUM_ADDR_BITS-1:0]  w_addr_nxt;

    logic [PACKET_BITS-1:0]    r_dout;
    logic [PACKET_BITS-1:0]    w_dout_nxt;

    logic                      w_full;
    logic                      w_empty;
    logic                      w_has_credit;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_launch;
    logic                      w_consume;

    // -------------------------------------------------------------------------
    // Handshake and status
    // -------------------------------------------------------------------------
    assign w_full       = (r_count == C_CNT_FULL);
    assign w_empty      = (r_count == '0);
    assign w_has_credit = (r_credits != '0);

    // ap_ack style: combinational, never while full, never in reset. A pop in
    // the same cycle does not open a slot for the incoming word.
    assign user_bft.ack_user = user_bft.vld_user & ~w_full & reset_n;
    assign w_push            = user_bft.ack_user;
    assign w_pop             = w_launch;

    assign user_bft.dout_bft = r_dout;

    // -------------------------------------------------------------------------
    // FSM next state plus launch/consume decisions
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_consume   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && w_has_credit) begin
                    w_launch    = 1'b1;
                    w_state_nxt = ST_SEND;
                end else if (!w_empty) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (user_bft.resend) begin
                    // Network rejected the packet: keep it on the bus untouched.
                    w_state_nxt = ST_SEND;
                end else begin
                    w_consume = 1'b1;
                    if (!w_empty && w_has_credit) begin
                        w_launch    = 1'b1;
                        w_state_nxt = ST_SEND;
                    end else if (!w_empty) begin
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_WAIT: begin
                if (!w_empty && w_has_credit) begin
                    w_launch    = 1'b1;
                    w_state_nxt = ST_SEND;
                end else if (w_empty) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Address, credit, FIFO occupancy and packet next-values
    // -------------------------------------------------------------------------
    always_comb begin
        // The address advances when the current packet is consumed, so a
        // back-to-back launch already carries the incremented address.
        if (w_consume) begin
            w_addr_nxt = r_addr + C_ADDR_ONE;
        end else begin
            w_addr_nxt = r_addr;
        end

        if (w_launch) begin
            w_cred_dec = r_credits - C_CRED_ONE;
        end else begin
            w_cred_dec = r_credits;
        end

        if (user_bft.credit_vld) begin
            w_cred_add = w_cred_dec + C_CRED_UPD;
        end else begin
            w_cred_add = w_cred_dec;
        end

        // Saturate after the net change so launch+update is +UPD-1 but
        // never exceeds the receiver BRAM depth.
        if (w_cred_add > C_CRED_INIT) begin
            w_credits_nxt = C_CRED_INIT;
        end else begin
            w_credits_nxt = w_cred_add;
        end

        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + C_CNT_ONE;
            2'b01:   w_count_nxt = r_count - C_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase

        if (w_launch) begin
            w_dout_nxt = {1'b1, cfg_dst_leaf, cfg_dst_port, w_addr_nxt, r_mem[r_rd_ptr]};
        end else if (w_consume) begin
            w_dout_nxt = '0;
        end else begin
            w_dout_nxt = r_dout;
        end
    end

    // -------------------------------------------------------------------------
    // Control and datapath registers with synchronous reset
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_bft) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_credits <= C_CRED_INIT;
            r_addr    <= '0;
            r_dout    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_credits <= w_credits_nxt;
            r_addr    <= w_addr_nxt;
            r_dout    <= w_dout_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FIFO storage; contents are don't-care once pointers are reset
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_bft) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= user_bft.din_user;
        end
    end

`ifdef PKT_STATS_EN
    // -------------------------------------------------------------------------
    // Optional statistics counters (wrap on overflow)
    // -------------------------------------------------------------------------
    logic [31:0] r_stat_pkts;
    logic [31:0] r_stat_resends;
    logic        w_resend_hold;

    assign w_resend_hold = (r_state == ST_SEND) & user_bft.resend;

    // Count consumed packets and rejected-packet cycles.
    always_ff @(posedge clk_bft) begin
        if (!reset_n) begin
            r_stat_pkts    <= 32'd0;
            r_stat_resends <= 32'd0;
        end else begin
            if (w_consume) begin
                r_stat_pkts <= r_stat_pkts + 32'd1;
            end
            if (w_resend_hold) begin
                r_stat_resends <= r_stat_resends + 32'd1;
            end
        end
    end

    assign stat_pkts_sent = r_stat_pkts;
    assign stat_resends   = r_stat_resends;
`endif

endmodule

// File: tb/tb_leaf_user2bft_packetizer.sv
// -----------------------------------------------------------------------------
// tb_leaf_user2bft_packetizer
// Directed bench for leaf_user2bft_packetizer. A queue-based model tracks the
// buffered words, credits, destination address and the packet on the bus; a
// compare process checks dout_bft and ack_user against it every cycle. Literal
// expectations pin the model for the headline scenarios.
// -----------------------------------------------------------------------------
module tb_leaf_user2bft_packetizer;

    localparam int DEPTH     = 8;
    localparam int CRED_INIT = 128;
    localparam int CRED_UPD  = 64;

    logic       clk_bft = 1'b0;
    logic       reset_n;
    logic [4:0] cfg_dst_leaf;
    logic [3:0] cfg_dst_port;
    bit         chk_en = 1'b0;

    leaf_user2bft_packetizer_if #(.PAYLOAD_BITS(32), .PACKET_BITS(49)) bus ();

`ifdef PKT_STATS_EN
    logic [31:0] stat_pkts_sent;
    logic [31:0] stat_resends;
`endif

    leaf_user2bft_packetizer dut (
        .clk_bft        (clk_bft),
        .reset_n        (reset_n),
        .cfg_dst_leaf   (cfg_dst_leaf),
        .cfg_dst_port   (cfg_dst_port),
`ifdef PKT_STATS_EN
        .stat_pkts_sent (stat_pkts_sent),
        .stat_resends   (stat_resends),
`endif
        .user_bft       (bus)
    );

    always #5 clk_bft = ~clk_bft;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------ model
    logic [31:0] mq[$];
    int          m_cred = CRED_INIT;
    int          m_addr = 0;
    logic [48:0] m_bus  = '0;
    int unsigned m_pkts = 0;
    int unsigned m_res  = 0;
    bit          m_acc, m_cons, m_launch;
    logic [31:0] m_w;

    always @(posedge clk_bft) begin
        if (reset_n !== 1'b1) begin
            mq.delete();
            m_cred = CRED_INIT;
            m_addr = 0;
            m_bus  = '0;
            m_pkts = 0;
            m_res  = 0;
        end else begin
            m_acc  = bus.vld_user && (mq.size() < DEPTH);
            m_cons = m_bus[48] && !bus.resend;
            if (m_bus[48] && bus.resend) m_res++;
            if (m_cons) begin
                m_addr = (m_addr + 1) % 128;
                m_pkts++;
            end
            m_launch = (!m_bus[48] || m_cons) && (mq.size() > 0) && (m_cred > 0);
            if (m_launch) begin
                m_w    = mq.pop_front();
                m_bus  = {1'b1, cfg_dst_leaf, cfg_dst_port, 7'(m_addr), m_w};
                m_cred = m_cred - 1;
            end else if (m_cons) begin
                m_bus = '0;
            end
            if (bus.credit_vld) m_cred = m_cred + CRED_UPD;
            if (m_cred > CRED_INIT) m_cred = CRED_INIT;
            if (m_acc) mq.push_back(bus.din_user);
        end
    end

    // ---------------------------------------------------- per-cycle compare
    always @(negedge clk_bft) begin
        if (chk_en) begin
            check("dout_bft", bus.dout_bft, m_bus);
            check("ack_user", bus.ack_user,
                  (bus.vld_user && reset_n && (mq.size() < DEPTH)));
`ifdef PKT_STATS_EN
            check("stat_pkts_sent", stat_pkts_sent, m_pkts);
            check("stat_resends", stat_resends, m_res);
`endif
        end
    end

    // ------------------------------------------- observed consumed packets
    logic [31:0] obs_pay[$];
    logic [6:0]  obs_addr[$];

    always @(posedge clk_bft) begin
        if (reset_n === 1'b1 && bus.dout_bft[48] === 1'b1 && bus.resend === 1'b0) begin
            obs_pay.push_back(bus.dout_bft[31:0]);
            obs_addr.push_back(bus.dout_bft[38:32]);
        end
    end

    // ------------------------------------------------------------ helpers
    task automatic tick();
        @(posedge clk_bft);
        #1;
    endtask

    task automatic do_reset();
        reset_n         = 1'b0;
        bus.vld_user    = 1'b0;
        bus.credit_vld  = 1'b0;
        bus.resend      = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        obs_pay.delete();
        obs_addr.delete();
    endtask

    task automatic push_word(input logic [31:0] w);
        bit done = 1'b0;
        bus.vld_user = 1'b1;
        bus.din_user = w;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk_bft);
            done = bus.ack_user;
            tick();
        end
        bus.vld_user = 1'b0;
        if (!done) begin
            n_total++;
            $display("FAIL push_timeout: word 0x%0h not accepted, expected acceptance", w);
        end
    endtask

    task automatic wait_count(input int n, input string name);
        int t = 0;
        while (obs_pay.size() < n && t < 2000) begin
            tick();
            t++;
        end
        repeat (10) tick();
        check(name, obs_pay.size(), n);
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        reset_n        = 1'b0;
        bus.vld_user   = 1'b1;
        bus.din_user   = 32'h1111_1111;
        bus.credit_vld = 1'b0;
        bus.resend     = 1'b0;
        cfg_dst_leaf   = 5'd3;
        cfg_dst_port   = 4'd1;

        // 1: reset held 3 cycles with vld_user high
        tick();
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_bft);
            check("t1_rst_ack", bus.ack_user, 1'b0);
            check("t1_rst_dout", bus.dout_bft, 49'd0);
            tick();
        end
        reset_n      = 1'b1;
        bus.vld_user = 1'b0;
        tick();

        // 2: single packet layout, then the following packet carries addr 1
        bus.vld_user = 1'b1;
        bus.din_user = 32'hDEADBEEF;
        tick();
        bus.din_user = 32'hCAFEF00D;
        tick();
        bus.vld_user = 1'b0;
        check("t2_pkt_a", bus.dout_bft, {1'b1, 5'd3, 4'd1, 7'd0, 32'hDEADBEEF});
        tick();
        check("t2_pkt_b", bus.dout_bft, {1'b1, 5'd3, 4'd1, 7'd1, 32'hCAFEF00D});
        tick();
        check("t2_idle", bus.dout_bft, 49'd0);

        // 3: 130 words with 128 credits, then one credit update
        do_reset();
        for (int i = 0; i < 130; i++) push_word(32'h0000_1000 + i);
        wait_count(128, "t3_count_128");
        check("t3_wait_dout", bus.dout_bft, 49'd0);
        check("t3_addr_127", obs_addr[127], 7'd127);
        bus.credit_vld = 1'b1;
        tick();
        bus.credit_vld = 1'b0;
        wait_count(130, "t3_count_130");
        check("t3_addr_wrap0", obs_addr[128], 7'd0);
        check("t3_addr_wrap1", obs_addr[129], 7'd1);
        check("t3_last_word", obs_pay[129], 32'h0000_1081);

        // 4: resend held 2 cycles keeps the packet for 3 cycles
        do_reset();
        cfg_dst_leaf = 5'd17;
        cfg_dst_port = 4'd9;
        bus.vld_user = 1'b1;
        bus.din_user = 32'hA1A1_0001;
        tick();
        bus.din_user = 32'hA2A2_0002;
        tick();
        bus.vld_user = 1'b0;
        check("t4_hold0", bus.dout_bft, {1'b1, 5'd17, 4'd9, 7'd0, 32'hA1A1_0001});
        bus.resend = 1'b1;
        tick();
        check("t4_hold1", bus.dout_bft, {1'b1, 5'd17, 4'd9, 7'd0, 32'hA1A1_0001});
        tick();
        check("t4_hold2", bus.dout_bft, {1'b1, 5'd17, 4'd9, 7'd0, 32'hA1A1_0001});
        bus.resend = 1'b0;
        tick();
        check("t4_next", bus.dout_bft, {1'b1, 5'd17, 4'd9, 7'd1, 32'hA2A2_0002});
        check("t4_count1", obs_pay.size(), 1);
        tick();
        check("t4_count2", obs_pay.size(), 2);

        // 5: drain stalled by resend; head word parked on the bus, FIFO fills
        do_reset();
        cfg_dst_leaf = 5'd3;
        cfg_dst_port = 4'd1;
        bus.resend   = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.vld_user = 1'b1;
            bus.din_user = 32'h0000_0500 + i;
            @(negedge clk_bft);
            check("t5_ack", bus.ack_user, 1'b1);
            tick();
        end
        bus.din_user = 32'h0000_0509;
        @(negedge clk_bft);
        check("t5_full_nack", bus.ack_user, 1'b0);
        tick();
        @(negedge clk_bft);
        check("t5_full_nack2", bus.ack_user, 1'b0);
        tick();
        bus.resend = 1'b0;
        push_word(32'h0000_0509);
        wait_count(10, "t5_count");
        for (int i = 0; i < 10; i++) check("t5_order", obs_pay[i], 32'h0000_0500 + i);
        check("t5_addr9", obs_addr[9], 7'd9);

        // 6a: credit update in the same cycle as a launch at credits=1 -> 64
        do_reset();
        for (int i = 0; i < 127; i++) push_word(32'h0000_2000 + i);
        wait_count(127, "t6_count_127");
        bus.vld_user = 1'b1;
        bus.din_user = 32'h0000_2FFF;
        tick();
        bus.vld_user   = 1'b0;
        bus.credit_vld = 1'b1;
        tick();
        bus.credit_vld = 1'b0;
        for (int i = 0; i < 70; i++) push_word(32'h0000_3000 + i);
        wait_count(192, "t6_count_192");
        check("t6_stall_dout", bus.dout_bft, 49'd0);

        // 6b: credit update at credits=100 saturates at 128
        do_reset();
        for (int i = 0; i < 28; i++) push_word(32'h0000_4000 + i);
        wait_count(28, "t6_count_28");
        bus.credit_vld = 1'b1;
        tick();
        bus.credit_vld = 1'b0;
        for (int i = 0; i < 132; i++) push_word(32'h0000_5000 + i);
        wait_count(156, "t6_count_156");
        check("t6_sat_dout", bus.dout_bft, 49'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
